// File: rtl/frame_sequencer_pkg.sv
// Shared definitions for the frame sequencer: one-hot state codes (also used as
// the seq_stat encoding), the default exposure timeout and the saturating shift.
package frame_sequencer_pkg;

    localparam int C_STATE_W         = 8;
    localparam int C_TIMEOUT_CYC_DEF = 16777216;
    localparam int C_SAT_W           = 64;

    typedef enum logic [C_STATE_W-1:0] {
        ST_IDLE     = 8'b0000_0001,
        ST_PARKED   = 8'b0000_0010,
        ST_RELEASE  = 8'b0000_0100,
        ST_EXPOSE   = 8'b0000_1000,
        ST_ADC_TRIG = 8'b0001_0000,
        ST_READOUT  = 8'b0010_0000,
        ST_NEXT     = 8'b0100_0000
    } seq_state_t;

    function automatic logic [31:0] sat_shl(input logic [31:0] base, input logic [1:0] sh);
        logic [C_SAT_W-1:0] w_wide;
        w_wide = {{(C_SAT_W-32){1'b0}}, base} << sh;
        return (|w_wide[C_SAT_W-1:32]) ? 32'hFFFF_FFFF : w_wide[31:0];
    endfunction

endpackage

// File: rtl/frame_seq_timeout.sv
// Loadable down-counter; o_expired flags terminal count while enabled.
module frame_seq_timeout #(
    parameter int C_CNT_W = 25
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic [C_CNT_W-1:0] i_load_val,
    input  logic               i_en,
    output logic               o_expired
);

    logic [C_CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = i_en && (r_cnt == '0);

endmodule

// File: rtl/frame_sequencer.sv
// Burst scheduler owning the FSMIND0/FSMIND1 handshake with the exposure FSM.
// Optional exposure bracketing is enabled by defining FRAME_SEQUENCER_BRACKET_EN.
//
//  state       | meaning
//  ------------+---------------------------------------------------------
//  IDLE        | after reset/timeout; wait for the free-running frame, flush it
//  PARKED      | exposure FSM held in restart-wait; wait for START
//  RELEASE     | FSMIND0 high until FSMIND0ACK
//  EXPOSE      | wait for FSMIND1, bounded by the timeout counter
//  ADC_TRIG    | one-cycle ADC_START; ADC_DONE ignored here
//  READOUT     | wait for ADC_DONE
//  NEXT        | decide end of burst or load next frame settings
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter int C_FRAME_W     = 16,
    parameter int C_TIMEOUT_CYC = C_TIMEOUT_CYC_DEF,
    parameter int C_BRK_MAX     = 3
) (
    input  logic                 CLKMPRE,
    input  logic                 RESET,
    input  logic                 START,
    input  logic                 STOP,
    input  logic [C_FRAME_W-1:0] NUM_FRAMES,
    input  logic [31:0]          Exp_base,
    input  logic [31:0]          Num_Pat_cfg,
    input  logic [1:0]           Brk_steps,
    input  logic                 FSMIND1,
    input  logic                 FSMIND0ACK,
    input  logic                 ADC_DONE,
    output logic                 FSMIND0,
    output logic                 FSMIND1ACK,
    output logic [31:0]          Exp_subc,
    output logic [31:0]          Num_Pat,
    output logic                 ADC_START,
    output logic [C_FRAME_W-1:0] FRAME_CNT,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 TIMEOUT_ERR,
    output logic [7:0]           seq_stat
);

    localparam int C_TO_W = $clog2(C_TIMEOUT_CYC + 1);

    seq_state_t           r_state;
    seq_state_t           w_state_nxt;
    logic [C_FRAME_W-1:0] r_frame_cnt;
    logic [31:0]          r_exp_subc;
    logic [31:0]          r_num_pat;
    logic                 r_stop_pending;
    logic                 r_timeout_err;
    logic                 r_done;
    logic                 w_start_burst;
    logic                 w_frame_adv;
    logic                 w_burst_end;
    logic                 w_to_fire;
    logic                 w_rd_done;
    logic                 w_to_load;
    logic                 w_to_expired;
    logic                 w_busy;
    logic [31:0]          w_exp_nxt;

    assign w_busy    = !((r_state == ST_IDLE) || (r_state == ST_PARKED));
    assign w_to_load = (r_state == ST_RELEASE) && FSMIND0ACK;

    frame_seq_timeout #(
        .C_CNT_W (C_TO_W)
    ) u_timeout (
        .i_clk      (CLKMPRE),
        .i_rst      (RESET),
        .i_load     (w_to_load),
        .i_load_val (C_TO_W'(C_TIMEOUT_CYC - 1)),
        .i_en       (r_state == ST_EXPOSE),
        .o_expired  (w_to_expired)
    );

    always_ff @(posedge CLKMPRE or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_start_burst = 1'b0;
        w_frame_adv   = 1'b0;
        w_burst_end   = 1'b0;
        w_to_fire     = 1'b0;
        w_rd_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (FSMIND1) w_state_nxt = ST_PARKED;
            end
            ST_PARKED: begin
                if (START) begin
                    w_state_nxt   = ST_RELEASE;
                    w_start_burst = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (FSMIND0ACK) w_state_nxt = ST_EXPOSE;
            end
            ST_EXPOSE: begin
                // A frame that completes on the expiry cycle is still accepted.
                if (FSMIND1) begin
                    w_state_nxt = ST_ADC_TRIG;
                end else if (w_to_expired) begin
                    w_state_nxt = ST_IDLE;
                    w_to_fire   = 1'b1;
                end
            end
            ST_ADC_TRIG: begin
                w_state_nxt = ST_READOUT;
            end
            ST_READOUT: begin
                if (ADC_DONE) begin
                    w_state_nxt = ST_NEXT;
                    w_rd_done   = 1'b1;
                end
            end
            ST_NEXT: begin
                if (r_stop_pending || STOP ||
                    ((NUM_FRAMES != '0) && (r_frame_cnt == NUM_FRAMES))) begin
                    w_state_nxt = ST_PARKED;
                    w_burst_end = 1'b1;
                end else begin
                    w_state_nxt = ST_RELEASE;
                    w_frame_adv = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef FRAME_SEQUENCER_BRACKET_EN
    localparam logic [1:0] C_BRK_LIM = (C_BRK_MAX > 3) ? 2'd3 : 2'(C_BRK_MAX);

    logic [1:0] r_slot;
    logic [1:0] w_brk_lim;
    logic [1:0] w_slot_nxt;

    assign w_brk_lim  = (Brk_steps > C_BRK_LIM) ? C_BRK_LIM : Brk_steps;
    assign w_slot_nxt = (r_slot >= w_brk_lim) ? 2'd0 : r_slot + 2'd1;
    assign w_exp_nxt  = sat_shl(Exp_base, w_slot_nxt);

    always_ff @(posedge CLKMPRE or posedge RESET) begin
        if (RESET) begin
            r_slot <= 2'd0;
        end else if (w_start_burst) begin
            r_slot <= 2'd0;
        end else if (w_frame_adv) begin
            r_slot <= w_slot_nxt;
        end
    end
`else
    logic [1:0] w_unused_brk;

    assign w_unused_brk = Brk_steps & 2'(C_BRK_MAX);
    assign w_exp_nxt    = Exp_base;
`endif

    always_ff @(posedge CLKMPRE or posedge RESET) begin
        if (RESET) begin
            r_frame_cnt    <= '0;
            r_exp_subc     <= '0;
            r_num_pat      <= '0;
            r_stop_pending <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= w_burst_end;
            if (w_start_burst) begin
                r_frame_cnt    <= '0;
                r_exp_subc     <= Exp_base;
                r_num_pat      <= Num_Pat_cfg;
                r_stop_pending <= 1'b0;
                r_timeout_err  <= 1'b0;
            end else begin
                if (w_busy && STOP) r_stop_pending <= 1'b1;
                if (w_burst_end)    r_stop_pending <= 1'b0;
                if (w_rd_done)      r_frame_cnt    <= r_frame_cnt + 1'b1;
                if (w_to_fire)      r_timeout_err  <= 1'b1;
                if (w_frame_adv) begin
                    r_exp_subc <= w_exp_nxt;
                    r_num_pat  <= Num_Pat_cfg;
                end
            end
        end
    end

    // ACK to the exposure FSM is held from end-of-exposure until the next restart is acknowledged.
    assign FSMIND0     = (r_state == ST_RELEASE);
    assign FSMIND1ACK  = (r_state == ST_PARKED)   || (r_state == ST_ADC_TRIG) ||
                         (r_state == ST_READOUT)  || (r_state == ST_NEXT)     ||
                         (r_state == ST_RELEASE);
    assign ADC_START   = (r_state == ST_ADC_TRIG);
    assign BUSY        = w_busy;
    assign DONE        = r_done;
    assign TIMEOUT_ERR = r_timeout_err;
    assign FRAME_CNT   = r_frame_cnt;
    assign Exp_subc    = r_exp_subc;
    assign Num_Pat     = r_num_pat;
    assign seq_stat    = r_state;

endmodule
